focal_max_col: RTL and testbench

- Vertical stage of the 3x3 focal-max pipeline, directly downstream of the row-max stage.
- Each beat it consumes one pair of 3-wide horizontal maxima (M, N) for the current raster row.
- It delays them through two row-length line buffers and emits the max of the same column pair across rows r-2, r-1 and r, which gives the 3x3 focal max.
- Streams with valid-only flow control and one registered cycle of latency.

---
 rtl/focal_max_col_if.sv | 20 ++
 rtl/focal_max_col.sv | 72 +++++++
 tb/tb_focal_max_col.sv | 132 +++++++++++++
 3 files changed

// File: rtl/focal_max_col_if.sv
// focal_max_col_if: M/N input stream and 3x3 focal-max result stream
interface focal_max_col_if;
  logic       frame_start;
  logic       in_valid;
  logic [3:0] in_m;
  logic [3:0] in_n;
  logic       out_valid;
  logic [3:0] out_m;
  logic [3:0] out_n;
  logic       out_last;
  logic       busy;
  modport master (
    output frame_start, in_valid, in_m, in_n,
    input  out_valid, out_m, out_n, out_last, busy
  );
  modport slave (
    input  frame_start, in_valid, in_m, in_n,
    output out_valid, out_m, out_n, out_last, busy
  );
endinterface

// File: rtl/focal_max_col.sv
// focal_max_col: vertical max over rows r-2..r of row-max pairs, giving the 3x3 focal max
module focal_max_col #(
  parameter  int COL_PAIRS = 4,
  localparam int CW        = COL_PAIRS > 1 ? $clog2(COL_PAIRS) : 1
) (
  input logic            clk,
  input logic            rst_n,
  focal_max_col_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL0  = 2'd1;
  localparam logic [1:0] FILL1  = 2'd2;
  localparam logic [1:0] STREAM = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    l1_q [COL_PAIRS];
  logic [7:0]    l2_q [COL_PAIRS];
  logic          out_valid_q, out_last_q;
  logic [3:0]    out_m_q, out_n_q;
  logic          acc, wrap, produce;
  logic [7:0]    h1, h2;
  function automatic logic [3:0] max3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return (a >= b && a >= c) ? a : (b >= c ? b : c);
  endfunction
  // a frame_start beat is accepted as row 0 col 0 even when coming out of IDLE
  always_comb begin
    acc     = bus.in_valid && (state_q != IDLE || bus.frame_start);
    wrap    = col_q == CW'(COL_PAIRS - 1);
    produce = acc && !bus.frame_start && state_q == STREAM;
    h1      = l1_q[COL_PAIRS-1];
    h2      = l2_q[COL_PAIRS-1];
    col_d   = bus.frame_start ? (bus.in_valid ? CW'(1) : '0)
            : acc ? (wrap ? '0 : col_q + 1'b1) : col_q;
    state_d = bus.frame_start ? FILL0
            : (acc && wrap && state_q != STREAM) ? state_q + 2'd1 : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_m_q     <= '0;
      out_n_q     <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      out_valid_q <= produce;
      out_last_q  <= produce && wrap;
      if (produce) begin
        out_m_q <= max3(bus.in_m, h1[7:4], h2[7:4]);
        out_n_q <= max3(bus.in_n, h1[3:0], h2[3:0]);
      end
    end
  end
  // buffer contents are masked by FILL0/FILL1, so they need no reset
  always_ff @(posedge clk) begin
    if (acc) begin
      l1_q[0] <= {bus.in_m, bus.in_n};
      l2_q[0] <= h1;
      for (int i = 1; i < COL_PAIRS; i++) begin
        l1_q[i] <= l1_q[i-1];
        l2_q[i] <= l2_q[i-1];
      end
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_m     = out_m_q;
  assign bus.out_n     = out_n_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_focal_max_col.sv
// tb_focal_max_col: directed stimulus with a row-image model feeding a result scoreboard
module tb_focal_max_col;
  localparam int CP = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  focal_max_col_if bus ();
  focal_max_col #(.COL_PAIRS(CP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, errors = 0, npulse = 0, nlast = 0;
  int p0, l0;
  logic [8:0] exp_q [$];
  logic [7:0] img [3][CP];
  logic [7:0] fr [16];
  int mrow = 0, mcol = 0;
  bit mact = 0;
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic logic [3:0] mx3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [3:0] t;
    t = a > b ? a : b;
    return t > c ? t : c;
  endfunction
  task automatic model(input logic [3:0] m, input logic [3:0] n, input logic fs);
    if (fs) begin mrow = 0; mcol = 0; mact = 1; end
    if (!mact) return;
    img[mrow % 3][mcol] = {m, n};
    if (mrow >= 2)
      exp_q.push_back({mx3(m, img[(mrow+1)%3][mcol][7:4], img[(mrow+2)%3][mcol][7:4]),
                       mx3(n, img[(mrow+1)%3][mcol][3:0], img[(mrow+2)%3][mcol][3:0]),
                       mcol == CP-1});
    mcol++;
    if (mcol == CP) begin mcol = 0; mrow++; end
  endtask
  task automatic beat(input logic [7:0] mn, input logic fs);
    @(negedge clk);
    bus.frame_start = fs;
    bus.in_valid = 1'b1;
    bus.in_m = mn[7:4];
    bus.in_n = mn[3:0];
    model(mn[7:4], mn[3:0], fs);
  endtask
  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.frame_start = 1'b0;
    end
  endtask
  always @(negedge clk) begin
    if (bus.out_valid) begin
      npulse++;
      if (bus.out_last) nlast++;
      if (exp_q.size() == 0) chk("spurious_out_valid", 12'd1, 12'd0);
      else chk("result", {bus.out_m, bus.out_n, bus.out_last}, exp_q.pop_front());
    end
  end
  initial begin
    bus.frame_start = 1'b0; bus.in_valid = 1'b0; bus.in_m = '0; bus.in_n = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.out_valid, bus.out_m, bus.out_n, bus.out_last}, 12'd0);
    chk("reset_busy", bus.busy, 0);
    rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.in_m = 4'h7; bus.in_n = 4'h7;
    repeat (5) @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_no_output", npulse, 0);
    idle(2);
    // frame A: two rows of F fill, then rows 2/3
    p0 = npulse; l0 = nlast;
    for (int i = 0; i < 16; i++) begin
      beat(i < 8 ? 8'hFF : (i == 8 ? 8'h12 : 8'($urandom)), i == 0);
      if (i == 8) chk("fill_masked", npulse - p0, 0);
      if (i == 9) #1 chk("fill_first", {bus.out_valid, bus.out_m, bus.out_n}, 12'h1FF);
    end
    idle(3);
    chk("a_pulses", npulse - p0, 8);
    chk("a_lasts", nlast - l0, 2);
    chk("a_busy_stream", bus.busy, 1);
    chk("a_hold", {bus.out_valid, bus.out_last}, 0);
    chk("a_queue_empty", exp_q.size(), 0);
    for (int i = 0; i < 16; i++) fr[i] = 8'($urandom);
    fr[0] = 8'h3A; fr[4] = 8'h92; fr[8] = 8'h57;
    fr[1] = 8'h66; fr[5] = 8'h66; fr[9] = 8'h66;
    p0 = npulse;
    for (int i = 0; i < 16; i++) begin
      beat(fr[i], i == 0);
      if (i == 9)  #1 chk("vmax_mixed", {bus.out_m, bus.out_n}, 12'h9A);
      if (i == 10) #1 chk("vmax_equal", {bus.out_m, bus.out_n}, 12'h66);
    end
    idle(3);
    chk("b_pulses", npulse - p0, 8);
    p0 = npulse; l0 = nlast;
    for (int i = 0; i < 16; i++) begin
      beat(fr[i], i == 0);
      idle(3);
      chk("gap_one_pulse_per_beat", npulse - p0, i >= 8 ? i - 7 : 0);
    end
    idle(2);
    chk("gap_pulses", npulse - p0, 8);
    chk("gap_lasts", nlast - l0, 2);
    chk("gap_queue_empty", exp_q.size(), 0);
    // restart at row 2 col 1 with a beat present
    p0 = npulse;
    for (int i = 0; i < 9; i++) beat(fr[i], i == 0);
    for (int i = 0; i < 12; i++) beat(8'($urandom), i == 0);
    idle(3);
    chk("restart_pulses", npulse - p0, 5);
    chk("restart_busy", bus.busy, 1);
    chk("restart_queue_empty", exp_q.size(), 0);
    for (int i = 0; i < 10; i++) beat(8'($urandom), i == 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midreset_outputs", {bus.out_valid, bus.out_m, bus.out_n, bus.out_last}, 12'd0);
    chk("midreset_busy", bus.busy, 0);
    exp_q.delete();
    mact = 0;
    p0 = npulse;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_busy", bus.busy, 0);
    chk("post_reset_no_output", npulse - p0, 0);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
